// File: rtl/decode_fetch.sv
// Instruction-byte fetch front end: strips legacy prefixes and the 0x0F
// escape, collects up to nine body bytes, and presents one decoded
// record per instruction with a valid/ready handshake.
module decode_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [71:0] unescaped_instr,
  output logic        escaped,
  output logic        prefix_operand_16bit,
  output logic        prefix_address_16bit,
  output logic        prefix_rep,
  output logic        prefix_lock,
  output logic [3:0]  body_len,
  output logic [3:0]  instr_len,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_PREFIX,
    S_BODY,
    S_DRAIN,
    S_EMIT
  } state_e;

  localparam logic [3:0] MAX_BODY  = 4'd9;
  localparam logic [3:0] MAX_TOTAL = 4'd15;

  state_e      state_q, state_d;
  logic [71:0] window_q, window_d;
  logic        esc_q, esc_d;
  logic        op16_q, op16_d;
  logic        addr16_q, addr16_d;
  logic        rep_q, rep_d;
  logic        lock_q, lock_d;
  logic [3:0]  body_len_q, body_len_d;
  logic [3:0]  instr_len_q, instr_len_d;
  logic        fault_q, fault_d;

  logic        accept;
  logic        is_prefix;

  assign in_ready  = (state_q != S_EMIT);
  assign out_valid = (state_q == S_EMIT);
  assign accept    = in_valid && in_ready;

  // Classify the incoming byte as one of the recognised legacy prefixes.
  always_comb begin
    is_prefix = 1'b0;
    case (in_byte)
      8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
      8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: is_prefix = 1'b1;
      default:                                  is_prefix = 1'b0;
    endcase
  end

  // Next-state and record-update logic for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    esc_d       = esc_q;
    op16_d      = op16_q;
    addr16_d    = addr16_q;
    rep_d       = rep_q;
    lock_d      = lock_q;
    body_len_d  = body_len_q;
    instr_len_d = instr_len_q;
    fault_d     = fault_q;

    case (state_q)
      S_PREFIX: begin
        if (accept) begin
          if (instr_len_q == MAX_TOTAL) begin
            // 16th byte overall: record is truncated, byte discarded.
            fault_d = 1'b1;
            state_d = in_last ? S_EMIT : S_DRAIN;
          end else begin
            instr_len_d = instr_len_q + 4'd1;
            if (is_prefix) begin
              if (in_byte == 8'h66) op16_d   = 1'b1;
              if (in_byte == 8'h67) addr16_d = 1'b1;
              if (in_byte == 8'hF0) lock_d   = 1'b1;
              if (in_byte == 8'hF2 || in_byte == 8'hF3) rep_d = 1'b1;
              if (in_last) begin
                fault_d = 1'b1;
                state_d = S_EMIT;
              end
            end else if (in_byte == 8'h0F) begin
              esc_d = 1'b1;
              if (in_last) begin
                fault_d = 1'b1;
                state_d = S_EMIT;
              end else begin
                state_d = S_BODY;
              end
            end else begin
              window_d[7:0] = in_byte;
              body_len_d    = 4'd1;
              state_d       = in_last ? S_EMIT : S_BODY;
            end
          end
        end
      end

      S_BODY: begin
        if (accept) begin
          if (body_len_q == MAX_BODY || instr_len_q == MAX_TOTAL) begin
            fault_d = 1'b1;
            if (instr_len_q != MAX_TOTAL) instr_len_d = instr_len_q + 4'd1;
            state_d = in_last ? S_EMIT : S_DRAIN;
          end else begin
            for (int unsigned k = 0; k < 9; k++) begin
              if (body_len_q == 4'(k)) window_d[k*8 +: 8] = in_byte;
            end
            body_len_d  = body_len_q + 4'd1;
            instr_len_d = instr_len_q + 4'd1;
            if (in_last) state_d = S_EMIT;
          end
        end
      end

      S_DRAIN: begin
        if (accept && in_last) state_d = S_EMIT;
      end

      S_EMIT: begin
        if (out_ready) begin
          state_d     = S_PREFIX;
          window_d    = '0;
          esc_d       = 1'b0;
          op16_d      = 1'b0;
          addr16_d    = 1'b0;
          rep_d       = 1'b0;
          lock_d      = 1'b0;
          body_len_d  = '0;
          instr_len_d = '0;
          fault_d     = 1'b0;
        end
      end

      default: state_d = S_PREFIX;
    endcase
  end

  // State and record registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PREFIX;
      window_q    <= '0;
      esc_q       <= 1'b0;
      op16_q      <= 1'b0;
      addr16_q    <= 1'b0;
      rep_q       <= 1'b0;
      lock_q      <= 1'b0;
      body_len_q  <= '0;
      instr_len_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      esc_q       <= esc_d;
      op16_q      <= op16_d;
      addr16_q    <= addr16_d;
      rep_q       <= rep_d;
      lock_q      <= lock_d;
      body_len_q  <= body_len_d;
      instr_len_q <= instr_len_d;
      fault_q     <= fault_d;
    end
  end

  assign unescaped_instr      = window_q;
  assign escaped              = esc_q;
  assign prefix_operand_16bit = op16_q;
  assign prefix_address_16bit = addr16_q;
  assign prefix_rep           = rep_q;
  assign prefix_lock          = lock_q;
  assign body_len             = body_len_q;
  assign instr_len            = instr_len_q;
  assign fault                = fault_q;

endmodule

// File: tb/tb_decode_fetch.sv
// Directed bench for decode_fetch: hand-computed records for ordinary,
// prefixed, escaped, overflowing and reset-interrupted instructions.
module tb_decode_fetch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] unescaped_instr;
  logic        escaped;
  logic        prefix_operand_16bit;
  logic        prefix_address_16bit;
  logic        prefix_rep;
  logic        prefix_lock;
  logic [3:0]  body_len;
  logic [3:0]  instr_len;
  logic        fault;

  int unsigned n_chk;
  int unsigned n_pass;

  decode_fetch dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_valid             (in_valid),
    .in_byte              (in_byte),
    .in_last              (in_last),
    .in_ready             (in_ready),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .unescaped_instr      (unescaped_instr),
    .escaped              (escaped),
    .prefix_operand_16bit (prefix_operand_16bit),
    .prefix_address_16bit (prefix_address_16bit),
    .prefix_rep           (prefix_rep),
    .prefix_lock          (prefix_lock),
    .body_len             (body_len),
    .instr_len            (instr_len),
    .fault                (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Present one byte for exactly one clock edge; in_ready must be high.
  task automatic send(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    chk("in_ready_before_byte", {71'd0, in_ready}, 72'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Check a complete record one cycle after its last-byte handshake.
  task automatic chk_rec(input string tag, input logic [71:0] win,
                         input logic esc, input logic op16, input logic a16,
                         input logic rep, input logic lock,
                         input logic [3:0] blen, input logic [3:0] ilen,
                         input logic flt);
    chk({tag, ".out_valid"}, {71'd0, out_valid}, 72'd1);
    chk({tag, ".in_ready"},  {71'd0, in_ready},  72'd0);
    chk({tag, ".window"},    unescaped_instr, win);
    chk({tag, ".flags"}, {67'd0, escaped, prefix_operand_16bit, prefix_address_16bit,
                          prefix_rep, prefix_lock},
                         {67'd0, esc, op16, a16, rep, lock});
    chk({tag, ".body_len"},  {68'd0, body_len},  {68'd0, blen});
    chk({tag, ".instr_len"}, {68'd0, instr_len}, {68'd0, ilen});
    chk({tag, ".fault"},     {71'd0, fault},     {71'd0, flt});
  endtask

  // Accept the pending record and confirm the front end is empty again.
  task automatic release_rec(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".cleared"},
        {out_valid, in_ready, unescaped_instr[15:0], body_len, instr_len, fault, escaped},
        {1'b0, 1'b1, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".window"}, unescaped_instr, 72'd0);
    chk({tag, ".misc"},
        {out_valid, in_ready, escaped, prefix_operand_16bit, prefix_address_16bit,
         prefix_rep, prefix_lock, body_len, instr_len, fault},
        {1'b0, 1'b1, 5'b0, 4'd0, 4'd0, 1'b0});
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;  // bytes offered during reset must be ignored
    in_byte   = 8'hAA;
    in_last   = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk_idle("reset");

    // Plain two-byte instruction.
    send(8'h89, 1'b0);
    chk("no_early_valid", {71'd0, out_valid}, 72'd0);
    send(8'hD8, 1'b1);
    chk_rec("plain", 72'h0000_0000_0000_00D8_89, 0, 0, 0, 0, 0, 4'd2, 4'd2, 0);
    release_rec("plain");

    // Prefixed and escaped instruction, then held under backpressure.
    send(8'h66, 1'b0);
    send(8'h67, 1'b0);
    send(8'hF3, 1'b0);
    send(8'h0F, 1'b0);
    send(8'hAF, 1'b0);
    send(8'hC1, 1'b1);
    chk_rec("prefixed", 72'h0000_0000_0000_00C1_AF, 1, 1, 1, 1, 0, 4'd2, 4'd6, 0);
    in_valid = 1'b1;
    in_byte  = 8'h90;
    in_last  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_rec("held", 72'h0000_0000_0000_00C1_AF, 1, 1, 1, 1, 0, 4'd2, 4'd6, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    release_rec("held");
    send(8'h90, 1'b1);
    chk_rec("after_hold", 72'h90, 0, 0, 0, 0, 0, 4'd1, 4'd1, 0);
    release_rec("after_hold");

    // Lock and 0xF2 rep with escape; body bytes that look like prefixes.
    send(8'hF0, 1'b0);
    send(8'hF2, 1'b0);
    send(8'h0F, 1'b0);
    send(8'h66, 1'b0);
    send(8'h0F, 1'b1);
    chk_rec("lock_rep", 72'h0F66, 1, 0, 0, 1, 1, 4'd2, 4'd5, 0);
    release_rec("lock_rep");

    // Body overflow: 01..0A, then two drained bytes, last on the 12th.
    for (int i = 1; i <= 10; i++) send(8'(i), 1'b0);
    chk("drain_no_valid", {71'd0, out_valid}, 72'd0);
    send(8'h0B, 1'b0);
    send(8'h0C, 1'b1);
    chk("ovf.out_valid", {71'd0, out_valid}, 72'd1);
    chk("ovf.window", unescaped_instr, 72'h09_08_07_06_05_04_03_02_01);
    chk("ovf.body_len", {68'd0, body_len}, 72'd9);
    chk("ovf.fault", {71'd0, fault}, 72'd1);
    release_rec("ovf");

    // Lone prefix flagged as last: no opcode.
    send(8'h66, 1'b1);
    chk_rec("lone_prefix", 72'd0, 0, 1, 0, 0, 0, 4'd0, 4'd1, 1);
    release_rec("lone_prefix");

    // Fifteen segment prefixes then an opcode: 16th byte overflows.
    for (int i = 0; i < 15; i++) send(8'h26, 1'b0);
    send(8'h90, 1'b1);
    chk_rec("total_ovf", 72'd0, 0, 0, 0, 0, 0, 4'd0, 4'd15, 1);
    release_rec("total_ovf");

    // Asynchronous reset in the middle of a body.
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("post_rst");
    send(8'h90, 1'b1);
    chk_rec("post_rst_rec", 72'h90, 0, 0, 0, 0, 0, 4'd1, 4'd1, 0);
    release_rec("post_rst_rec");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_fetch.md
DECODE_FETCH -- requirements
Module: decode_fetch

Interface
REQ-001 SHALL have clock port clk (input, 1): single clock; all state on its rising edge.
REQ-002 SHALL have reset port rst_n (input, 1): reset is asynchronous and active-low.
REQ-003 SHALL have in_valid (input, 1): upstream byte valid.
REQ-004 SHALL have in_byte (input, 8): raw instruction byte, program order.
REQ-005 SHALL have in_last (input, 1): in_byte is the final byte of the current instruction.
REQ-006 SHALL have in_ready (output, 1): byte accepted when in_valid && in_ready.
REQ-007 SHALL have out_valid (output, 1): decoded-instruction record valid.
REQ-008 SHALL have out_ready (input, 1): downstream (operand decode) accepts record.
REQ-009 SHALL have unescaped_instr (output, 72): body bytes, first body byte at [7:0], byte k at [8k+7:8k].
REQ-010 SHALL have escaped (output, 1): instruction carried a 0x0F escape.
REQ-011 SHALL have prefix_operand_16bit and prefix_address_16bit (outputs, 1 each): 0x66 / 0x67 seen.
REQ-012 SHALL have prefix_rep (output, 1): 0xF2 or 0xF3 seen; prefix_lock (output, 1): 0xF0 seen.
REQ-013 SHALL have body_len (output, 4): body bytes stored, 0-9; instr_len (output, 4): total bytes consumed, 1-15.
REQ-014 SHALL have fault (output, 1): record is malformed; qualified by out_valid.

Function
REQ-015 SHALL implement states PREFIX, BODY, DRAIN, EMIT; reset state PREFIX.
REQ-016 in_ready SHALL be 1 in PREFIX, BODY, DRAIN and 0 in EMIT; out_valid SHALL be 1 only in EMIT.
REQ-017 PREFIX: accepted bytes 0x66, 0x67, 0xF0, 0xF2, 0xF3, 0x26, 0x2E, 0x36, 0x3E, 0x64, 0x65 SHALL set the matching flag (segment prefixes: no flag), not be stored, stay in PREFIX; repeats are legal.
REQ-018 PREFIX: accepted 0x0F SHALL set escaped, not be stored, go to BODY; any other byte SHALL be stored as body byte 0 and go to BODY.
REQ-019 BODY: every accepted byte SHALL be stored at index body_len then increment body_len; prefix values and 0x0F SHALL be stored as ordinary bytes.
REQ-020 Every accepted byte in PREFIX/BODY SHALL increment instr_len.
REQ-021 Accepted byte with in_last=1 in PREFIX or BODY (without overflow) SHALL go to EMIT next cycle; out_valid rises exactly one cycle after the last-byte handshake.
REQ-022 in_last=1 on a prefix or 0x0F byte in PREFIX state SHALL go to EMIT with fault=1 (no opcode).
REQ-023 Overflow: accepting a 10th body byte, or a 16th total byte, with in_last=0 SHALL set fault, go to DRAIN; with in_last=1 SHALL set fault, go to EMIT. Overflowing byte not stored; body_len/instr_len saturate at 9/15.
REQ-024 DRAIN SHALL accept and discard bytes until an in_last handshake, then go to EMIT.
REQ-025 EMIT: all outputs SHALL hold stable while out_valid && !out_ready.
REQ-026 On out_valid && out_ready, state SHALL return to PREFIX and clear window, flags, counters, fault in the same edge; next byte accepted no earlier than the following cycle.
REQ-027 Unwritten window bytes SHALL read 8'h00.
REQ-028 Throughput SHALL be one byte per cycle while in_valid=1 and not in EMIT.

Reset
REQ-029 On rst_n=0, asynchronously: state=PREFIX, unescaped_instr=0, all flags=0, body_len=0, instr_len=0, fault=0, out_valid=0, in_ready=1 after release.
REQ-030 Reset mid-instruction (PREFIX/BODY/DRAIN/EMIT) SHALL discard partial record; no record emitted.
REQ-031 Bytes presented during reset SHALL NOT be accepted.

Verification
REQ-032 Bytes 89 D8(last) -> out_valid 1 cycle later, unescaped_instr[15:0]=16'hD889, upper bits 0, body_len=2, instr_len=2, all flags 0, fault=0.
REQ-033 Bytes 66 67 F3 0F AF C1(last) -> unescaped_instr[15:0]=16'hC1AF, escaped=1, op16=1, addr16=1, rep=1, body_len=2, instr_len=6.
REQ-034 Record held with out_ready=0 for 5 cycles while in_valid=1 -> outputs constant, in_ready=0, no bytes consumed; out_ready=1 -> return to PREFIX.
REQ-035 Ten body bytes 01..0A, in_last on the 12th byte -> fault=1, body_len=9, window=bytes 01..09, out_valid one cycle after byte 12.
REQ-036 Single byte 66 with in_last -> fault=1, op16=1, body_len=0, instr_len=1.
REQ-037 rst_n low while in BODY after 3 bytes -> immediately all outputs zero; subsequent 90(last) yields body_len=1, instr_len=1.
